// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
//
// Sequencing controller for the primary scrambler LFSR (POLY_WIDTH bits).
// A host hands over a full seed on a valid/ready handshake. The controller
// writes it into the LFSR as NWORDS consecutive 32-bit register writes. A
// separate step request then drives the LFSR enable for run_len steps. Each
// resulting LFSR state is presented as a back-pressurable keystream word.
// This block is the only master of the LFSR write/addr/din/enable pins.
//
// Parameters:
//   POLY_WIDTH  LFSR width, 193..224 (so NWORDS = 7)
//   BASE_ADDR   register address of seed word 0; word k lives at BASE_ADDR+k
//   LEN_W       width of the step-count request
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   seed_valid/seed_ready/seed     seed handshake (POLY_WIDTH bits)
//   run_valid/run_ready/run_len    step-request handshake (LEN_W bits)
//   lfsr_write/addr/din/enable     LFSR load and step controls
//   lfsr_dout                      current LFSR state
//   ks_valid/ks_ready/ks_data      keystream output, ks_data = lfsr_dout
//   busy                           controller is not idle
//   seeded                         a seed has been loaded since reset
//   done                           one-cycle pulse when a run completes
//   seed_err                       one-cycle pulse when a seed is rejected
//
// Build option:
//   LFSR_ZERO_SEED_CHECK_EN  when defined, an all-zero seed is consumed but
//                            not loaded, and seed_err pulses instead. When
//                            undefined, zero seeds load normally and
//                            seed_err is tied low.
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
    parameter int          POLY_WIDTH = 195,
    parameter logic [11:0] BASE_ADDR  = 12'h0e8,
    parameter int          LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [POLY_WIDTH-1:0] seed,

    input  logic                  run_valid,
    output logic                  run_ready,
    input  logic [LEN_W-1:0]      run_len,

    output logic                  lfsr_write,
    output logic [11:0]           lfsr_addr,
    output logic [31:0]           lfsr_din,
    output logic                  lfsr_enable,
    input  logic [POLY_WIDTH-1:0] lfsr_dout,

    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [POLY_WIDTH-1:0] ks_data,

    output logic                  busy,
    output logic                  seeded,
    output logic                  done,
    output logic                  seed_err
);

    localparam int NWORDS = (POLY_WIDTH + 31) / 32;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam int PAD_W  = NWORDS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Seed held zero-extended to a whole number of words. The padding bits
    // above POLY_WIDTH-1 therefore reach lfsr_din as zeros on the final write.
    logic [PAD_W-1:0] r_seed;
    logic [IDX_W-1:0] r_idx;
    logic             r_seeded;
    logic [LEN_W-1:0] r_remaining;
    logic             r_ks_valid;
    logic             r_done;

    logic             w_in_idle;
    logic             w_in_load;
    logic             w_in_run;
    logic             w_seed_acc;
    logic             w_seed_load;
    logic             w_run_acc;
    logic             w_run_zero;
    logic             w_slot_free;
    logic             w_run_en;
    logic             w_run_fin;
    logic             w_load_last;
    logic [31:0]      w_seed_word;

    assign w_in_idle   = (r_state == S_IDLE);
    assign w_in_load   = (r_state == S_LOAD);
    assign w_in_run    = (r_state == S_RUN);

    // A pending seed always takes priority over a run request.
    assign w_seed_acc  = seed_valid & w_in_idle;
    assign w_run_acc   = run_valid & w_in_idle & r_seeded & ~seed_valid;
    assign w_run_zero  = (run_len == '0);

`ifdef LFSR_ZERO_SEED_CHECK_EN
    logic w_seed_zero;
    logic w_seed_rej;
    logic r_seed_err;

    assign w_seed_zero = (seed == '0);
    assign w_seed_load = w_seed_acc & ~w_seed_zero;
    assign w_seed_rej  = w_seed_acc & w_seed_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed_err <= 1'b0;
        end else begin
            r_seed_err <= w_seed_rej;
        end
    end

    assign seed_err = r_seed_err;
`else
    assign w_seed_load = w_seed_acc;
    assign seed_err    = 1'b0;
`endif

    // The output slot is free when nothing is pending or when the pending word
    // is consumed this cycle. A step then overwrites lfsr_dout safely.
    assign w_slot_free = ~r_ks_valid | ks_ready;
    assign w_run_en    = w_in_run & (r_remaining != '0) & w_slot_free;
    // The run finishes only after the last word has been consumed.
    assign w_run_fin   = w_in_run & (r_remaining == '0) & w_slot_free;
    assign w_load_last = w_in_load & (r_idx == LAST_IDX);

    assign w_seed_word = r_seed[{r_idx, 5'd0} +: 32];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_seed_load) begin
                    w_state_nxt = S_LOAD;
                end else if (w_run_acc && !w_run_zero) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_run_fin) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // Enable and write live in different states, so enable is never asserted
    // during a load. The LFSR gives enable priority over load, so this
    // separation is required.
    // ---------------------------------------------------------------------
    always_comb begin
        seed_ready  = 1'b0;
        run_ready   = 1'b0;
        lfsr_write  = 1'b0;
        lfsr_addr   = '0;
        lfsr_din    = '0;
        lfsr_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                seed_ready = 1'b1;
                run_ready  = r_seeded & ~seed_valid;
            end
            S_LOAD: begin
                lfsr_write = 1'b1;
                lfsr_addr  = BASE_ADDR + 12'(r_idx);
                lfsr_din   = w_seed_word;
            end
            S_RUN: begin
                lfsr_enable = w_run_en;
            end
            default: begin
                seed_ready = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control registers: word index, seeded flag, step counter,
    // keystream valid and done pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_seeded    <= 1'b0;
            r_remaining <= '0;
            r_ks_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_seed_load) begin
                r_idx <= '0;
            end else if (w_in_load) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_load_last) begin
                r_seeded <= 1'b1;
            end

            if (w_run_acc && !w_run_zero) begin
                r_remaining <= run_len;
            end else if (w_run_en) begin
                r_remaining <= r_remaining - 1'b1;
            end

            // A fresh word appears after every step. Otherwise a pending word
            // stays until it is consumed.
            if (w_run_en) begin
                r_ks_valid <= 1'b1;
            end else if (ks_ready) begin
                r_ks_valid <= 1'b0;
            end

            // A zero-length request completes at once without stepping.
            r_done <= (w_run_acc & w_run_zero) | w_run_fin;
        end
    end

    // ---------------------------------------------------------------------
    // Seed data register (no reset: only read after a capture)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_seed_load) begin
            r_seed <= PAD_W'(seed);
        end
    end

    assign busy     = ~w_in_idle;
    assign seeded   = r_seeded;
    assign done     = r_done;
    assign ks_valid = r_ks_valid;
    assign ks_data  = lfsr_dout;

endmodule
